// File: rtl/qgemm_absmax_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : qgemm_absmax_ctrl
//  Description : Sequencing controller for the qgemm absolute-max reduction
//                path. Accepts a tile of num_rows_i rows over a valid/ready
//                stream and routes each accepted row to an external
//                combinational max-finder. Folds the per-row maxima into a
//                running tile maximum, then presents the tile max exponent
//                and mantissa on a valid/ready result port.
//  Ports       : clk_i, rst_i                 clock / sync active-high reset
//                start_i, num_rows_i          tile request and row count
//                busy_o, cfg_err_o            status / illegal-count pulse
//                row_valid_i/_ready_o/_data_i row beat stream
//                mf_data_o, mf_max_exp_i,
//                mf_max_mant_i                max-finder hookup
//                res_valid_o/_ready_i,
//                res_max_exp_o/_mant_o,
//                res_zero_o                   tile result
//  Revision    : 1.0  initial release
// ============================================================================
module qgemm_absmax_ctrl #(
    parameter  int MAT_SIZE  = 16,
    parameter  int FP_DATA_W = 32,
    parameter  int FP_EXP_W  = 8,
    parameter  int FP_MANT_W = 23,
    parameter  int MAX_ROWS  = 16,
    localparam int ROW_CNT_W = $clog2(MAX_ROWS + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [ROW_CNT_W-1:0]          num_rows_i,
    output logic                          busy_o,
    output logic                          cfg_err_o,
    input  logic                          row_valid_i,
    output logic                          row_ready_o,
    input  logic [FP_DATA_W*MAT_SIZE-1:0] row_data_i,
    output logic [FP_DATA_W*MAT_SIZE-1:0] mf_data_o,
    input  logic [FP_EXP_W-1:0]           mf_max_exp_i,
    input  logic [FP_MANT_W-1:0]          mf_max_mant_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [FP_EXP_W-1:0]           res_max_exp_o,
    output logic [FP_MANT_W-1:0]          res_max_mant_o,
    output logic                          res_zero_o
);

    localparam logic [ROW_CNT_W-1:0] c_max_rows = ROW_CNT_W'(MAX_ROWS);
    localparam logic [ROW_CNT_W-1:0] c_one      = ROW_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ROW_CNT_W-1:0]   r_rows_left;
    logic [FP_EXP_W-1:0]    r_max_exp;
    logic [FP_MANT_W-1:0]   r_max_mant;
    logic                   r_cfg_err;

    logic                   w_legal;
    logic                   w_start_ok;
    logic                   w_cfg_err_set;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_take;
    logic [FP_EXP_W+FP_MANT_W:0] w_run_key;
    logic [FP_EXP_W+FP_MANT_W:0] w_mf_key;

    assign w_legal       = (num_rows_i != '0) && (num_rows_i <= c_max_rows);
    assign w_start_ok    = (r_state == ST_IDLE) && start_i && w_legal;
    assign w_cfg_err_set = (r_state == ST_IDLE) && start_i && !w_legal;
    assign w_accept      = (r_state == ST_COLLECT) && row_valid_i;
    assign w_last        = w_accept && (r_rows_left == c_one);

    // Ordering key {exp, hidden, mant}: larger exponent wins first, then the
    // significand including the implicit bit. Strict greater-than keeps the
    // running value on a tie.
    assign w_run_key = {r_max_exp, (r_max_exp != '0), r_max_mant};
    assign w_mf_key  = {mf_max_exp_i, (mf_max_exp_i != '0), mf_max_mant_i};
    assign w_take    = (w_mf_key > w_run_key);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        busy_o      = 1'b0;
        row_ready_o = 1'b0;
        res_valid_o = 1'b0;
        mf_data_o   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                busy_o      = 1'b1;
                row_ready_o = 1'b1;
                mf_data_o   = row_data_i;
                if (w_last) begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                busy_o      = 1'b1;
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Row counter, running maximum and error pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rows_left <= '0;
            r_max_exp   <= '0;
            r_max_mant  <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_err_set;
            if (w_start_ok) begin
                r_rows_left <= num_rows_i;
                r_max_exp   <= '0;
                r_max_mant  <= '0;
            end else if (w_accept) begin
                r_rows_left <= r_rows_left - c_one;
                if (w_take) begin
                    r_max_exp  <= mf_max_exp_i;
                    r_max_mant <= mf_max_mant_i;
                end
            end
        end
    end

    assign cfg_err_o      = r_cfg_err;
    assign res_max_exp_o  = r_max_exp;
    assign res_max_mant_o = r_max_mant;
    assign res_zero_o     = (r_max_exp == '0) && (r_max_mant == '0);

endmodule
`default_nettype wire

// File: tb/tb_qgemm_absmax_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qgemm_absmax_ctrl
//  Description : Self-checking bench for qgemm_absmax_ctrl. Provides a
//                behavioural max-finder, a tile-level reference model based
//                on 31-bit magnitude ordering, and directed tile scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qgemm_absmax_ctrl;

    localparam int MS = 16;
    localparam int DW = 32;
    localparam int EW = 8;
    localparam int MW = 23;
    localparam int MR = 16;
    localparam int RW = 5;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [RW-1:0]     num_rows_i;
    logic              busy_o;
    logic              cfg_err_o;
    logic              row_valid_i;
    logic              row_ready_o;
    logic [DW*MS-1:0]  row_data_i;
    logic [DW*MS-1:0]  mf_data_o;
    logic [EW-1:0]     mf_max_exp_i;
    logic [MW-1:0]     mf_max_mant_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [EW-1:0]     res_max_exp_o;
    logic [MW-1:0]     res_max_mant_o;
    logic              res_zero_o;

    always #5 clk = ~clk;

    qgemm_absmax_ctrl #(
        .MAT_SIZE (MS), .FP_DATA_W(DW), .FP_EXP_W(EW), .FP_MANT_W(MW), .MAX_ROWS(MR)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .num_rows_i    (num_rows_i),
        .busy_o        (busy_o),
        .cfg_err_o     (cfg_err_o),
        .row_valid_i   (row_valid_i),
        .row_ready_o   (row_ready_o),
        .row_data_i    (row_data_i),
        .mf_data_o     (mf_data_o),
        .mf_max_exp_i  (mf_max_exp_i),
        .mf_max_mant_i (mf_max_mant_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_max_exp_o (res_max_exp_o),
        .res_max_mant_o(res_max_mant_o),
        .res_zero_o    (res_zero_o)
    );

    // For IEEE fields with hidden=(exp!=0), ordering by {exp,hidden,mant}
    // equals unsigned ordering of the 31-bit magnitude.
    function automatic logic [30:0] row_mag_max(input logic [DW*MS-1:0] d);
        logic [30:0] best;
        logic [31:0] w;
        best = '0;
        for (int i = 0; i < MS; i++) begin
            w = d[i*DW +: DW];
            if (w[30:0] > best) best = w[30:0];
        end
        return best;
    endfunction

    // Behavioural combinational max-finder
    logic [30:0] mf_best;
    assign mf_best       = row_mag_max(mf_data_o);
    assign mf_max_exp_i  = mf_best[30:23];
    assign mf_max_mant_i = mf_best[22:0];

    // Row builder: lane pos carries mx, other lanes smaller magnitudes of
    // alternating sign.
    function automatic logic [DW*MS-1:0] make_row(input logic [31:0] mx, input int idx);
        logic [DW*MS-1:0] r;
        logic [30:0]      mag;
        logic [31:0]      w;
        int               pos;
        mag = mx[30:0];
        pos = (idx * 5) % MS;
        r   = '0;
        for (int k = 0; k < MS; k++) begin
            w = {k[0], mag >> (k + 1)};
            if (k == pos) w = mx;
            r[k*DW +: DW] = w;
        end
        return r;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW*MS-1:0] act, input logic [DW*MS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tile-level reference model: mode 0 idle, 1 collecting, 2 presenting
    int          m_mode = 0;
    int          m_left = 0;
    logic [30:0] m_max  = '0;
    bit          m_err  = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst_i) begin
            m_mode = 0;
            m_max  = '0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            case (m_mode)
                0: if (start_i) begin
                       if (num_rows_i >= 1 && num_rows_i <= MR) begin
                           m_left = int'(num_rows_i);
                           m_max  = '0;
                           m_mode = 1;
                       end else begin
                           m_err = 1'b1;
                       end
                   end
                1: if (row_valid_i) begin
                       if (row_mag_max(row_data_i) > m_max) m_max = row_mag_max(row_data_i);
                       m_left--;
                       if (m_left == 0) m_mode = 2;
                   end
                default: if (res_ready_i) m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",      busy_o,      (m_mode != 0));
            check("row_ready", row_ready_o, (m_mode == 1));
            check("res_valid", res_valid_o, (m_mode == 2));
            check("cfg_err",   cfg_err_o,   m_err);
            check("mf_data",   mf_data_o,   (m_mode == 1) ? row_data_i : '0);
            check("res_exp",   res_max_exp_o,  m_max[30:23]);
            check("res_mant",  res_max_mant_o, m_max[22:0]);
            check("res_zero",  res_zero_o,  (m_max == '0));
        end
    end

    logic [31:0] tmax [MS];

    task automatic set4(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        tmax[0] = a; tmax[1] = b; tmax[2] = c; tmax[3] = d;
    endtask

    task automatic start_tile(input int n);
        start_i    = 1'b1;
        num_rows_i = RW'(n);
        @(posedge clk); #1;
        start_i    = 1'b0;
    endtask

    task automatic send_rows(input int n, input bit gaps);
        int g;
        for (int i = 0; i < n; i++) begin
            g = 0;
            while (gaps && g < 3 && $urandom_range(0, 2) == 0) begin
                row_valid_i = 1'b0;
                row_data_i  = make_row(32'h7F7FFFFF, i);
                @(posedge clk); #1;
                g++;
            end
            row_valid_i = 1'b1;
            row_data_i  = make_row(tmax[i], i);
            @(posedge clk); #1;
        end
        row_valid_i = 1'b0;
        row_data_i  = '0;
    endtask

    task automatic wait_result(input string name, input logic [EW-1:0] e,
                               input logic [MW-1:0] m, input logic z);
        int k;
        k = 0;
        while (!res_valid_o && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check({name, "_valid"}, res_valid_o, 1'b1);
        check({name, "_exp"},   res_max_exp_o, e);
        check({name, "_mant"},  res_max_mant_o, m);
        check({name, "_zero"},  res_zero_o, z);
    endtask

    task automatic handshake();
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        check("hs_idle", busy_o, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; num_rows_i = '0;
        row_valid_i = 1'b0; row_data_i = '0; res_ready_i = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  busy_o, 1'b0);
        check("rst_zero",  res_zero_o, 1'b1);
        check("rst_exp",   res_max_exp_o, '0);
        check("rst_valid", res_valid_o, 1'b0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Basic tile: 1.0, 3.5, -8.0, 2.0
        set4(32'h3F800000, 32'h40600000, 32'hC1000000, 32'h40000000);
        start_tile(4);
        send_rows(4, 1'b0);
        check("basic_latency", res_valid_o, 1'b1);
        wait_result("basic", 8'h82, 23'h000000, 1'b0);
        handshake();

        // Mantissa tie-break, both orders, and equal maxima
        set4(32'h40400000, 32'hC0600000, 0, 0);
        start_tile(2); send_rows(2, 1'b0);
        wait_result("tie_a", 8'h80, 23'h600000, 1'b0);
        handshake();
        set4(32'hC0600000, 32'h40400000, 0, 0);
        start_tile(2); send_rows(2, 1'b0);
        wait_result("tie_b", 8'h80, 23'h600000, 1'b0);
        handshake();
        set4(32'h40400000, 32'hC0400000, 0, 0);
        start_tile(2); send_rows(2, 1'b0);
        wait_result("tie_eq", 8'h80, 23'h400000, 1'b0);
        handshake();

        // Stalls with a full 16-row tile; max 100.0 in row 7
        for (int i = 0; i < MS; i++) tmax[i] = 32'h3F800000 + 32'(i) * 32'h00010000;
        tmax[7] = 32'h42C80000;
        start_tile(16);
        send_rows(16, 1'b1);
        wait_result("stall", 8'h85, 23'h480000, 1'b0);

        // Back-pressure for 5 cycles with an ignored start
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                start_i = 1'b1; num_rows_i = 5'd3;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            check("bp_valid", res_valid_o, 1'b1);
            check("bp_ready", row_ready_o, 1'b0);
            check("bp_exp",   res_max_exp_o, 8'h85);
            check("bp_mant",  res_max_mant_o, 23'h480000);
        end
        // start on the handshake cycle is ignored too
        res_ready_i = 1'b1; start_i = 1'b1; num_rows_i = 5'd2;
        @(posedge clk); #1;
        res_ready_i = 1'b0; start_i = 1'b0;
        check("hs_start_ignored", busy_o, 1'b0);
        @(posedge clk); #1;
        check("hs_still_idle", busy_o, 1'b0);

        // Config errors
        start_tile(0);
        check("err0_pulse", cfg_err_o, 1'b1);
        check("err0_busy",  busy_o, 1'b0);
        @(posedge clk); #1;
        check("err0_clear", cfg_err_o, 1'b0);
        start_tile(17);
        check("err17_pulse", cfg_err_o, 1'b1);
        check("err17_busy",  busy_o, 1'b0);
        @(posedge clk); #1;
        check("err17_clear", cfg_err_o, 1'b0);

        // All-zero tile and subnormal tile
        set4(32'h00000000, 32'h80000000, 32'h00000000, 0);
        start_tile(3); send_rows(3, 1'b0);
        wait_result("zero", 8'h00, 23'h000000, 1'b1);
        handshake();
        set4(32'h00000001, 32'h80000003, 32'h00000002, 0);
        start_tile(3); send_rows(3, 1'b0);
        wait_result("subn", 8'h00, 23'h000003, 1'b0);
        handshake();

        // Reset mid-tile after 2 of 4 rows
        set4(32'h7F000000, 32'h41000000, 32'h3F800000, 32'h3F800000);
        start_tile(4); send_rows(2, 1'b0);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check("mid_rst_busy",  busy_o, 1'b0);
        check("mid_rst_ready", row_ready_o, 1'b0);
        check("mid_rst_valid", res_valid_o, 1'b0);
        check("mid_rst_exp",   res_max_exp_o, '0);
        check("mid_rst_mant",  res_max_mant_o, '0);
        check("mid_rst_zero",  res_zero_o, 1'b1);
        tmax[0] = 32'h3F800000;
        start_tile(1); send_rows(1, 1'b0);
        wait_result("after_rst", 8'h7F, 23'h000000, 1'b0);
        handshake();

        // Back-to-back tiles: 8.0 then 0.5
        set4(32'h41000000, 32'h3F800000, 0, 0);
        start_tile(2); send_rows(2, 1'b0);
        wait_result("b2b_first", 8'h82, 23'h000000, 1'b0);
        set4(32'h3F000000, 32'hBE800000, 0, 0);
        handshake();
        start_tile(2);
        check("b2b_busy", busy_o, 1'b1);
        check("b2b_cleared", res_max_exp_o, 8'h00);
        send_rows(2, 1'b0);
        wait_result("b2b_second", 8'h7E, 23'h000000, 1'b0);
        handshake();

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/qgemm_absmax_ctrl.md
# qgemm_absmax_ctrl

Sequencing controller for the qgemm absolute-max reduction path. It accepts a tile of `num_rows` rows, each `MAT_SIZE` FP values wide, over a valid/ready stream and steers each accepted row onto an external combinational max-finder. It folds the per-row maxima into a running tile maximum and presents the tile max exponent and mantissa on a valid/ready result port. Downstream, the quantizer uses this result for shared-scale generation.

## Interface
- `MAT_SIZE`, 16, lanes per row; power of two; matches the max-finder instance.
- `FP_DATA_W`, 32, FP word width.
- `FP_EXP_W`, 8, exponent field width.
- `FP_MANT_W`, 23, mantissa field width.
- `MAX_ROWS`, 16, largest legal tile row count.
- `ROW_CNT_W`, localparam = clog2(`MAX_ROWS`+1).

Ports:
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  one-cycle request to begin a tile; honoured only in IDLE.
- `num_rows_i`  in  `ROW_CNT_W`  rows in the tile; sampled when `start_i` is accepted.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `cfg_err_o`  out  1  one-cycle pulse when `start_i` arrives in IDLE with `num_rows_i`==0 or `num_rows_i`>`MAX_ROWS`.
- `row_valid_i`  in  1  row beat valid.
- `row_ready_o`  out  1  row beat ready.
- `row_data_i`  in  `FP_DATA_W`*`MAT_SIZE`  row beat; lane i is at [(i+1)*`FP_DATA_W`-1 -: `FP_DATA_W`].
- `mf_data_o`  out  `FP_DATA_W`*`MAT_SIZE`  data to the max-finder.
- `mf_max_exp_i`  in  `FP_EXP_W`  raw exponent from the max-finder.
- `mf_max_mant_i`  in  `FP_MANT_W`  mantissa from the max-finder.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  result ready.
- `res_max_exp_o`  out  `FP_EXP_W`  tile max raw exponent.
- `res_max_mant_o`  out  `FP_MANT_W`  tile max mantissa.
- `res_zero_o`  out  1  high when the tile maximum is +0, i.e. every lane is ±0.

## Operation
- The FSM has three states: IDLE, COLLECT and OUTPUT.
- **IDLE**
  - `start_i` with a legal `num_rows_i` latches the row count into `rows_left`.
  - The running max is cleared to exp=0, mant=0.
  - The FSM moves to COLLECT.
  - `start_i` with an illegal `num_rows_i` pulses `cfg_err_o` and the FSM stays in IDLE.
- **COLLECT**
  - `row_ready_o`=1.
  - `mf_data_o`=`row_data_i`. In all other states, `mf_data_o`=0.
  - A beat is accepted when `row_valid_i`&&`row_ready_o`.
  - On an accepted beat, the running max is updated with {`mf_max_exp_i`,`mf_max_mant_i`} in the same cycle, and `rows_left` decrements.
  - The beat on which `rows_left`==1 is the last; the FSM then moves to OUTPUT.
- **Compare rule** (identical to the max-finder's pick rule)
  - The larger exponent wins.
  - On equal exponents, the larger {hidden, mant} wins, where hidden=(exp!=0).
  - A tie keeps the running value.
  - Sign is already stripped by the max-finder.
  - NaN and Inf are not special-cased; they compare as raw fields.
- **OUTPUT**
  - `res_valid_o`=1, and the result fields are held stable.
  - `res_zero_o`=(exp==0 && mant==0).
  - On `res_valid_o`&&`res_ready_i`, the FSM moves to IDLE.
- `start_i` is ignored outside IDLE, including on the cycle of the result handshake. No error pulse is produced in that case.
- `rst_i` at any time, mid-tile included, forces IDLE and the reset output values below. A partial tile is discarded and no result is produced.

## Timing
- Output reset values:
  - `busy_o`=0, `cfg_err_o`=0, `row_ready_o`=0, `res_valid_o`=0.
  - `mf_data_o`=0, `res_max_exp_o`=0, `res_max_mant_o`=0.
  - `res_zero_o`=1.
- Start acceptance: `start_i` sampled at edge t gives `busy_o`=1 and `row_ready_o`=1 from t+1.
- Row throughput is one row per cycle with no bubbles. The max-finder path is combinational within the accepting cycle.
- Latency: the last row accepted at edge t gives `res_valid_o`=1 from t+1, carrying the final max.
- Back-to-back tiles:
  - Handshake at edge t gives IDLE at t+1.
  - The earliest next start is sampled at t+1; COLLECT follows at t+2.
- Minimum tile period is N+2 cycles, with `res_ready_i` tied high.
- Back-pressure: `res_valid_o` and the result fields hold until `res_ready_i`. `row_ready_o`=0 throughout OUTPUT.
- `cfg_err_o` is registered. An illegal start sampled at t gives the pulse high only during cycle t+1.

## Test plan
- **Basic tile.** Start with N=4; rows have max |x| of 1.0, 3.5, -8.0 and 2.0. Required: result exp=0x82, mant=0x000000, `res_zero_o`=0. `res_valid_o` rises exactly one cycle after the 4th beat.
- **Mantissa tie-break.** Start with N=2; row maxima are 0x40400000 (3.0) and 0xC0600000 (-3.5). Required: exp=0x80, mant=0x600000.
  - Swap the row order: the result is identical.
  - Two equal maxima: the result is unchanged.
- **Stalls and back-pressure.**
  - Random `row_valid_i` gaps with N=MAX_ROWS=16: exactly 16 beats are accepted and the max is correct.
  - Hold `res_ready_i`=0 for 5 cycles: the result stays stable, `row_ready_o`=0, and a `start_i` during this window is ignored.
- **Config errors and zero tile.**
  - Start with N=0 or N=17: one-cycle `cfg_err_o`, `busy_o` stays 0.
  - Tile of N=3 all-±0 rows: exp=0, mant=0, `res_zero_o`=1.
  - Subnormal-only tile with a maximum of 0x00000003: exp=0, mant=3, `res_zero_o`=0.
- **Reset mid-tile.** Assert `rst_i` after 2 of 4 rows.
  - Required next cycle: IDLE, all outputs at their reset values.
  - A subsequent N=1 tile with max 0x3F800000 returns exp=0x7F, mant=0, with no influence from the aborted tile.
- **Back-to-back tiles.** Assert `start_i` one cycle after the result handshake.
  - Required: the second tile starts from a cleared max.
  - The second result reflects only its own rows; for example, a 0.5 max gives exp=0x7E even though the first tile's max was 8.0.
